// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder
//   Receives PS/2 set-2 scan codes and turns them into the game's control signals.
//   The outputs use the same encoding as the old SW[3:0]/SW[4] switch mapping:
//   direction[3]=up, [2]=down, [1]=left, [0]=right. start is high while S is held.
// Ports
//   clock      system clock
//   resetn     asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_dat    raw PS/2 data (asynchronous)
//   direction  one-hot level of the held arrow key; the last key pressed wins
//   start      level, high while S (0x1B) is held
//   dir_pulse  1-cycle strobe on each new arrow make; typematic repeats do not pulse
//   frame_err  1-cycle strobe on a bad stop bit, a timeout or (optionally) a parity error
// Configuration
//   PS2_PARITY_CHECK_EN: when defined, a frame whose data plus parity bits do not have an
//   odd 1s-count is rejected with frame_err. When undefined, the parity bit is ignored.

module ps2_direction_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] direction,
  output logic       start,
  output logic       dir_pulse,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_hist_q;
  logic                   clk_s, dat_s, fall;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] to_cnt_q, to_cnt_d;
  logic            timeout, byte_valid;

  logic [3:0] direction_q, direction_d;
  logic       start_q, start_d;
  logic       dir_pulse_q, dir_pulse_d;
  logic       frame_err_q, frame_err_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [3:0] arrow_oh;

  assign clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
  assign dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign dat_s      = dat_sync_q[SYNC_STAGES-1];
  assign fall       = clk_hist_q & ~clk_s;

  // A falling edge in the same cycle as the timeout wins.
  assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

`ifndef PS2_PARITY_CHECK_EN
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

  // Receiver: advances only on synchronised ps2_clk falling edges.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    frame_err_d = 1'b0;
    byte_valid  = 1'b0;

    if (state_q == StIdle || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + CntW'(1);
    end

    if (timeout) begin
      state_d     = StIdle;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = dat_s;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!dat_s) begin
            frame_err_d = 1'b1;
          end else begin
`ifdef PS2_PARITY_CHECK_EN
            if (^{shift_q, parity_q}) byte_valid = 1'b1;
            else                      frame_err_d = 1'b1;
`else
            byte_valid = 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    case (shift_q)
      8'h75:   arrow_oh = 4'b1000;
      8'h72:   arrow_oh = 4'b0100;
      8'h6B:   arrow_oh = 4'b0010;
      8'h74:   arrow_oh = 4'b0001;
      default: arrow_oh = 4'b0000;
    endcase
  end

  // Decoder: acts on the completed byte in the cycle it becomes valid.
  always_comb begin
    direction_d = direction_q;
    start_d     = start_q;
    dir_pulse_d = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;

    if (byte_valid) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q && (arrow_oh != 4'b0000)) begin
          if (!brk_q) begin
            direction_d = arrow_oh;
            dir_pulse_d = (direction_q != arrow_oh);
          end else if (direction_q == arrow_oh) begin
            direction_d = 4'b0000;
          end
        end else if (!ext_q && (shift_q == 8'h1B)) begin
          start_d = !brk_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // Lines idle high, so sync and history flops reset high to avoid a false edge.
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_hist_q  <= 1'b1;
      state_q     <= StIdle;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      direction_q <= 4'b0000;
      start_q     <= 1'b0;
      dir_pulse_q <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_hist_q  <= clk_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      direction_q <= direction_d;
      start_q     <= start_d;
      dir_pulse_q <= dir_pulse_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  assign direction = direction_q;
  assign start     = start_q;
  assign dir_pulse = dir_pulse_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Testbench for ps2_direction_decoder: drives PS/2 frames with random bit timing and compares
// the decoder outputs against a key-state model kept in the bench.

module tb_ps2_direction_decoder;

  localparam int unsigned To = 200;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] direction;
  logic       start;
  logic       dir_pulse;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  logic [3:0] m_dir = 4'b0000;
  logic       m_start = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  int         m_pulses = 0;
  int         m_errs = 0;

  ps2_direction_decoder #(
    .TIMEOUT_CYCLES(To),
    .SYNC_STAGES   (2)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .direction(direction),
    .start    (start),
    .dir_pulse(dir_pulse),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (dir_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [3:0] arrow_of(input logic [7:0] b);
    case (b)
      8'h75:   return 4'b1000;
      8'h72:   return 4'b0100;
      8'h6B:   return 4'b0010;
      8'h74:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] oh;
    oh = arrow_of(b);
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (m_ext && oh != 4'b0000) begin
        if (!m_brk) begin
          if (m_dir != oh) m_pulses++;
          m_dir = oh;
        end else if (m_dir == oh) begin
          m_dir = 4'b0000;
        end
      end else if (!m_ext && b == 8'h1B) begin
        m_start = !m_brk;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_dir = 4'b0000;
    m_start = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB-first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] bits;
    int h;
    h = $urandom_range(4, 12);
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_dat = bits[i];
      repeat (h) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (h) @(negedge clock);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(b, bad_par, bad_stop, 11);
    repeat (8) @(negedge clock);
    if (bad_stop) begin
      m_errs++;
    end else begin
`ifdef PS2_PARITY_CHECK_EN
      if (bad_par) m_errs++;
      else         model_byte(b);
`else
      model_byte(b);
`endif
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({direction, start, dir_pulse, frame_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset: outputs got %b required 0000000",
               {direction, start, dir_pulse, frame_err});
    end
    resetn = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_press_release();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (direction !== 4'b1000 || pulse_cnt !== 1) begin
      errors++;
      $display("FAIL press_up: dir=%b pulses=%0d required 1000 and 1", direction, pulse_cnt);
    end
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (direction !== 4'b0000 || pulse_cnt !== 1) begin
      errors++;
      $display("FAIL release_up: dir=%b pulses=%0d required 0000 and 1", direction, pulse_cnt);
    end
  endtask

  task automatic test_last_wins();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h6B, 0, 0);
    checks++;
    if (direction !== 4'b0010) begin
      errors++;
      $display("FAIL left: dir got %b required 0010", direction);
    end
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    checks++;
    if (direction !== 4'b0001 || pulse_cnt !== m_pulses) begin
      errors++;
      $display("FAIL right: dir=%b pulses=%0d required 0001 and %0d", direction, pulse_cnt,
               m_pulses);
    end
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    checks++;
    if (direction !== 4'b0001) begin
      errors++;
      $display("FAIL stale_release: dir got %b required 0001", direction);
    end
  endtask

  task automatic test_typematic();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hE0, 0, 0);
      send_frame(8'h72, 0, 0);
    end
    checks++;
    if (direction !== 4'b0100 || pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL typematic: dir=%b new_pulses=%0d required 0100 and 1", direction,
               pulse_cnt - p0);
    end
  endtask

  task automatic test_start_key();
    send_frame(8'h1B, 0, 0);
    checks++;
    if (start !== 1'b1 || direction !== 4'b0100) begin
      errors++;
      $display("FAIL start_press: start=%b dir=%b required 1 and 0100", start, direction);
    end
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1B, 0, 0);
    checks++;
    if (start !== 1'b0 || direction !== 4'b0100) begin
      errors++;
      $display("FAIL start_release: start=%b dir=%b required 0 and 0100", start, direction);
    end
  endtask

  task automatic test_frame_errors();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1B, 0, 1);
    checks++;
    if (err_cnt - e0 !== 1 || {direction, start} !== {m_dir, m_start}) begin
      errors++;
      $display("FAIL bad_stop: errs=%0d dir/start=%b required 1 and %b", err_cnt - e0,
               {direction, start}, {m_dir, m_start});
    end
    send_bits(8'h75, 0, 0, 5);
    repeat (To + 20) @(negedge clock);
    m_errs++;
    checks++;
    if (err_cnt - e0 !== 2 || {direction, start} !== {m_dir, m_start}) begin
      errors++;
      $display("FAIL timeout: errs=%0d dir/start=%b required 2 and %b", err_cnt - e0,
               {direction, start}, {m_dir, m_start});
    end
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (direction !== 4'b1000) begin
      errors++;
      $display("FAIL after_timeout: dir got %b required 1000", direction);
    end
  endtask

  task automatic test_parity();
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 1, 0);
    checks++;
`ifdef PS2_PARITY_CHECK_EN
    if (direction !== 4'b0000 || err_cnt !== m_errs) begin
      errors++;
      $display("FAIL bad_parity: dir=%b errs=%0d required 0000 and %0d", direction, err_cnt,
               m_errs);
    end
`else
    if (direction !== 4'b1000 || err_cnt !== m_errs) begin
      errors++;
      $display("FAIL bad_parity: dir=%b errs=%0d required 1000 and %0d", direction, err_cnt,
               m_errs);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] b;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1B, 8'hE0};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else                           b = pool[$urandom_range(0, 7)];
      send_frame(b, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      checks++;
      if ({direction, start} !== {m_dir, m_start} || pulse_cnt !== m_pulses ||
          err_cnt !== m_errs) begin
        errors++;
        $display("FAIL random[%0d] byte %h: dir/start=%b pulses=%0d errs=%0d required %b %0d %0d",
                 i, b, {direction, start}, pulse_cnt, err_cnt, {m_dir, m_start}, m_pulses,
                 m_errs);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h1B, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_bits(8'hF0, 0, 0, 5);
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({direction, start, dir_pulse, frame_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid: outputs got %b required 0000000",
               {direction, start, dir_pulse, frame_err});
    end
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (direction !== 4'b1000 || start !== 1'b0 || pulse_cnt !== m_pulses) begin
      errors++;
      $display("FAIL after_reset: dir=%b start=%b pulses=%0d required 1000 0 %0d", direction,
               start, pulse_cnt, m_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_last_wins();
    test_typematic();
    test_start_key();
    test_frame_errors();
    test_parity();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
